servo_sweep_controller: RTL and testbench



---
 rtl/servo_pkg.sv | 37 +++
 rtl/servo_frame_timer.sv | 47 ++++
 rtl/servo_sweep_controller.sv | 157 +++++++++++++++
 tb/tb_servo_sweep_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo sweep controller and its frame timer:
//   - servo_state_e           : controller state encoding (IDLE, RAMP, SETTLE)
//   - DUTY_MIN_DEFAULT        : default lowest legal duty count (park position)
//   - DUTY_MAX_DEFAULT        : default highest legal duty count
//   - FRAME_CYCLES_20MS_25MHZ : clock cycles in one 20 ms PWM frame at 25 MHz
//   - clamp_duty()            : saturate a value into [lo, hi]
// -----------------------------------------------------------------------------
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } servo_state_e;

    localparam int unsigned DUTY_MIN_DEFAULT        = 21;
    localparam int unsigned DUTY_MAX_DEFAULT        = 102;
    localparam int unsigned FRAME_CYCLES_20MS_25MHZ = 500_000;

    // Saturating clamp; callers zero-extend narrower words to 32 bits.
    function automatic int unsigned clamp_duty(
        input int unsigned value,
        input int unsigned lo,
        input int unsigned hi
    );
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// -----------------------------------------------------------------------------
// servo_frame_timer
// Free-running frame counter 0 .. FRAME_CYCLES-1 with a one-cycle tick on the
// last cycle of each frame. Only reset clears it, so a PWM serializer sharing
// this timer stays phase-aligned with the duty updates.
//
// Ports:
//   clk_i        in   system clock
//   reset_i      in   synchronous active-high reset
//   frame_tick_o out  high exactly when the count equals FRAME_CYCLES-1
// -----------------------------------------------------------------------------
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_20MS_25MHZ
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic frame_tick_o
);

    localparam int unsigned      CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_CYCLES - 1);

    if (FRAME_CYCLES < 1) begin : g_bad_frame_cycles
        $error("servo_frame_timer: FRAME_CYCLES must be at least 1");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/servo_sweep_controller.sv
// -----------------------------------------------------------------------------
// servo_sweep_controller
// Produces the duty word for the servo PWM serializer. A target arrives over a
// valid/ready handshake, is clamped to [DUTY_MIN, DUTY_MAX], and the duty then
// slews toward it by at most STEP counts per frame. Once there, the controller
// holds for HOLD_FRAMES further frames and pulses done.
//
// Ports:
//   CLK25MHZ   in   system clock, 25 MHz
//   reset      in   synchronous active-high reset
//   cmd_valid  in   target command valid
//   cmd_ready  out  high only in IDLE; a transfer is cmd_valid && cmd_ready
//   cmd_target in   requested duty count (clamped on accept)
//   duty_cycle out  registered duty word, changes only after a frame tick
//   frame_tick out  one-cycle pulse on the last cycle of each frame
//   busy       out  high in RAMP and SETTLE
//   done       out  one-cycle pulse when the hold completes
// -----------------------------------------------------------------------------
module servo_sweep_controller
    import servo_pkg::*;
#(
    parameter int unsigned DUTY_WIDTH   = 10,
    parameter int unsigned DUTY_MIN     = DUTY_MIN_DEFAULT,
    parameter int unsigned DUTY_MAX     = DUTY_MAX_DEFAULT,
    parameter int unsigned STEP         = 1,
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_20MS_25MHZ,
    parameter int unsigned HOLD_FRAMES  = 4
) (
    input  logic                  CLK25MHZ,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DUTY_WIDTH-1:0] cmd_target,
    output logic [DUTY_WIDTH-1:0] duty_cycle,
    output logic                  frame_tick,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned           HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [DUTY_WIDTH-1:0] STEP_W = DUTY_WIDTH'(STEP);

    // Elaboration-time parameter legality.
    if (DUTY_WIDTH < 1 || DUTY_WIDTH > 31) begin : g_bad_width
        $error("servo_sweep_controller: DUTY_WIDTH must be in 1..31");
    end
    if (DUTY_MIN > DUTY_MAX) begin : g_bad_range
        $error("servo_sweep_controller: DUTY_MIN must not exceed DUTY_MAX");
    end
    if (64'(DUTY_MAX) >= (64'(1) << DUTY_WIDTH)) begin : g_bad_max
        $error("servo_sweep_controller: DUTY_MAX does not fit in DUTY_WIDTH bits");
    end
    if (STEP < 1 || 64'(STEP) >= (64'(1) << DUTY_WIDTH)) begin : g_bad_step
        $error("servo_sweep_controller: STEP must be >= 1 and fit in DUTY_WIDTH bits");
    end

    servo_state_e          state_q;
    logic [DUTY_WIDTH-1:0] duty_q;
    logic [DUTY_WIDTH-1:0] duty_d;
    logic [DUTY_WIDTH-1:0] target_q;
    logic [DUTY_WIDTH-1:0] target_d;
    logic [DUTY_WIDTH-1:0] diff;
    logic [HOLD_W-1:0]     hold_q;
    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  tick;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .clk_i        (CLK25MHZ),
        .reset_i      (reset),
        .frame_tick_o (tick)
    );

    always_comb begin
        target_d = DUTY_WIDTH'(clamp_duty(32'(cmd_target), DUTY_MIN, DUTY_MAX));
    end

    // Slew-limited next duty. The magnitude compare comes first so the
    // subtraction is always non-negative, and the final step lands exactly on
    // the target instead of overshooting it.
    always_comb begin
        // NOTE: defaults first; a path that skips an assignment would infer a latch.
        duty_d = duty_q;
        diff   = '0;
        if (duty_q < target_q) begin
            diff   = target_q - duty_q;
            duty_d = (diff > STEP_W) ? duty_q + STEP_W : target_q;
        end else if (duty_q > target_q) begin
            diff   = duty_q - target_q;
            duty_d = (diff > STEP_W) ? duty_q - STEP_W : target_q;
        end
    end

    always_ff @(posedge CLK25MHZ) begin
        if (reset) begin
            state_q     <= IDLE;
            duty_q      <= DUTY_WIDTH'(DUTY_MIN);
            target_q    <= DUTY_WIDTH'(DUTY_MIN);
            hold_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A tick coinciding with the accept is deliberately not
                    // used: the first step happens on the following tick.
                    if (cmd_valid && cmd_ready_q) begin
                        target_q    <= target_d;
                        state_q     <= RAMP;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                RAMP: begin
                    if (tick) begin
                        duty_q <= duty_d;
                        // Leave on the tick whose update reaches the target
                        // (immediately if it was already there at accept).
                        if (duty_d == target_q) begin
                            state_q <= SETTLE;
                            hold_q  <= HOLD_W'(HOLD_FRAMES);
                        end
                    end
                end
                SETTLE: begin
                    if (tick) begin
                        if (hold_q == '0) begin
                            state_q     <= IDLE;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign duty_cycle = duty_q;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_tick = tick;

endmodule

// File: tb/tb_servo_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_servo_sweep_controller
// Directed bench with two controller instances sharing one clock and a
// 10-cycle frame: A uses STEP=1, HOLD_FRAMES=2; B uses STEP=3, HOLD_FRAMES=0.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_servo_sweep_controller;

    localparam int FC = 10;
    localparam int W  = 10;

    logic         clk = 1'b0;
    logic         rst_a, rst_b;
    logic         valid_a, valid_b;
    logic         ready_a, ready_b;
    logic [W-1:0] target_a, target_b;
    logic [W-1:0] duty_a, duty_b;
    logic         tick_a, tick_b;
    logic         busy_a, busy_b;
    logic         done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    servo_sweep_controller #(
        .DUTY_WIDTH (W), .DUTY_MIN (21), .DUTY_MAX (102),
        .STEP (1), .FRAME_CYCLES (FC), .HOLD_FRAMES (2)
    ) dut_a (
        .CLK25MHZ   (clk),
        .reset      (rst_a),
        .cmd_valid  (valid_a),
        .cmd_ready  (ready_a),
        .cmd_target (target_a),
        .duty_cycle (duty_a),
        .frame_tick (tick_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    servo_sweep_controller #(
        .DUTY_WIDTH (W), .DUTY_MIN (21), .DUTY_MAX (102),
        .STEP (3), .FRAME_CYCLES (FC), .HOLD_FRAMES (0)
    ) dut_b (
        .CLK25MHZ   (clk),
        .reset      (rst_b),
        .cmd_valid  (valid_b),
        .cmd_ready  (ready_b),
        .cmd_target (target_b),
        .duty_cycle (duty_b),
        .frame_tick (tick_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge at which the selected frame_tick is high.
    task automatic wait_tick(input bit sel_b);
        for (int i = 0; i < 2 * FC; i++) begin
            @(negedge clk);
            if ((sel_b ? tick_b : tick_a) === 1'b1) return;
        end
        n_cmp++;
        n_bad++;
        $error("FAIL tick_timeout: observed no frame_tick expected one within %0d cycles", 2 * FC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_done;

        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        target_a = '0; target_b = '0;

        // ---- Reset state ------------------------------------------------
        repeat (3) @(negedge clk);
        check("rst_duty_a",  duty_a,  21);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a",  busy_a,  0);
        check("rst_done_a",  done_a,  0);
        check("rst_tick_a",  tick_a,  0);
        check("rst_duty_b",  duty_b,  21);
        rst_a = 1'b0; rst_b = 1'b0;

        // ---- Frame tick every 10th cycle after release ------------------
        for (int i = 1; i <= 2 * FC; i++) begin
            @(negedge clk);
            check("tick_period_a", tick_a, ((i % FC) == FC - 1) ? 1 : 0);
            check("tick_period_b", tick_b, ((i % FC) == FC - 1) ? 1 : 0);
        end

        // ---- A: ramp up 21 -> 25, hold 2, done after 7 ticks ------------
        valid_a = 1'b1; target_a = 25;
        @(negedge clk);
        valid_a = 1'b0;
        check("acc_ready_a", ready_a, 0);
        check("acc_busy_a",  busy_a,  1);
        check("acc_duty_a",  duty_a,  21);
        for (int k = 1; k <= 4; k++) begin
            wait_tick(1'b0);
            check("ramp_ready_a", ready_a, 0);
            @(negedge clk);
            check("ramp_up_a", duty_a, 21 + k);
        end
        for (int f = 5; f <= 7; f++) begin
            wait_tick(1'b0);
            check("hold_ready_a", ready_a, 0);
            check("hold_busy_a",  busy_a,  1);
            @(negedge clk);
            check("hold_done_a", done_a, (f == 7) ? 1 : 0);
            if (f == 7) begin
                check("done_ready_a", ready_a, 1);
                check("done_busy_a",  busy_a,  0);
            end
        end
        @(negedge clk);
        check("done_pulse_end_a", done_a, 0);
        check("final_duty_a",     duty_a, 25);

        // ---- A: command held during RAMP is ignored until IDLE ----------
        valid_a = 1'b1; target_a = 30;
        @(negedge clk);
        target_a = 50;
        for (int k = 1; k <= 5; k++) begin
            wait_tick(1'b0);
            @(negedge clk);
            check("busy_ignore_duty_a", duty_a, 25 + k);
        end
        for (int f = 6; f <= 8; f++) begin
            wait_tick(1'b0);
            @(negedge clk);
            check("busy_ignore_done_a", done_a, (f == 8) ? 1 : 0);
        end
        check("ready_at_done_a", ready_a, 1);
        @(negedge clk);
        valid_a = 1'b0;
        check("late_accept_ready_a", ready_a, 0);
        check("late_accept_busy_a",  busy_a,  1);
        check("late_accept_duty_a",  duty_a,  30);
        wait_tick(1'b0);
        @(negedge clk);
        check("late_target_step_a", duty_a, 31);

        // ---- B: target equals duty, HOLD=0, accepted on a tick cycle ----
        wait_tick(1'b1);
        valid_b = 1'b1; target_b = 21;
        @(negedge clk);
        valid_b = 1'b0;
        check("eq_busy_b", busy_b, 1);
        wait_tick(1'b1);
        check("eq_done_t1_b", done_b, 0);
        @(negedge clk);
        check("eq_duty_t1_b", duty_b, 21);
        check("eq_busy_t1_b", busy_b, 1);
        check("eq_done_after_t1_b", done_b, 0);
        wait_tick(1'b1);
        @(negedge clk);
        check("eq_done_t2_b",  done_b,  1);
        check("eq_duty_t2_b",  duty_b,  21);
        check("eq_ready_t2_b", ready_b, 1);

        // ---- B: STEP=3 up to 25 (24, 25) --------------------------------
        valid_b = 1'b1; target_b = 25;
        @(negedge clk);
        valid_b = 1'b0;
        wait_tick(1'b1); @(negedge clk);
        check("up3_step1_b", duty_b, 24);
        wait_tick(1'b1); @(negedge clk);
        check("up3_step2_b", duty_b, 25);
        wait_tick(1'b1); @(negedge clk);
        check("up3_done_b", done_b, 1);

        // ---- B: target 5 clamps to 21, no undershoot (22, 21) -----------
        valid_b = 1'b1; target_b = 5;
        @(negedge clk);
        valid_b = 1'b0;
        wait_tick(1'b1); @(negedge clk);
        check("down_step1_b", duty_b, 22);
        wait_tick(1'b1); @(negedge clk);
        check("down_step2_b", duty_b, 21);
        wait_tick(1'b1); @(negedge clk);
        check("down_done_b", done_b, 1);
        check("down_final_b", duty_b, 21);

        // ---- B: target 1000 saturates at 102 ----------------------------
        valid_b = 1'b1; target_b = 1000;
        @(negedge clk);
        valid_b = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            wait_tick(1'b1); @(negedge clk);
            check("sat_ramp_b", duty_b, 21 + 3 * k);
        end
        wait_tick(1'b1); @(negedge clk);
        check("sat_done_b", done_b, 1);
        check("sat_duty_b", duty_b, 102);

        // ---- B: reset mid-ramp at duty 60 -------------------------------
        valid_b = 1'b1; target_b = 0;
        @(negedge clk);
        valid_b = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            wait_tick(1'b1); @(negedge clk);
            check("mid_ramp_b", duty_b, 102 - 3 * k);
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("midrst_duty_b",  duty_b,  21);
        check("midrst_busy_b",  busy_b,  0);
        check("midrst_ready_b", ready_b, 1);
        check("midrst_done_b",  done_b,  0);
        seen_done = 0;
        repeat (3 * FC) begin
            @(negedge clk);
            if (done_b === 1'b1) seen_done++;
        end
        check("midrst_no_done_b", seen_done, 0);
        check("midrst_idle_duty_b", duty_b, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
